spu_event_counter: RTL and testbench
====================================

// Module: spu_event_counter
// PURPOSE
// Receive end of the SPU event interface driven by the event unit (EVU). Samples per-cycle
// event pulses (e_id), context info (e_info = {priv[1:0], asid}) and source id (s_id).
// Keeps one CNT_WIDTH counter per event line, gated by privilege/ASID filters, with
// per-line thresholds, sticky hit/overflow flags and a level interrupt. The SPU core reads
// and configures it over a simple single-cycle register port.
// PARAMETERS
// NUM_EVENTS  4   event lines in e_id; legal range 1..16
// ASID_WIDTH  16  asid field width in e_info (must match the EVU)
// CNT_WIDTH   32  counter and threshold width; legal range 1..32
// SRC_ID      0   s_id value accepted; events carrying any other s_id are dropped
// PORTS
// clk_i        in   1                single clock
// rst_ni       in   1                asynchronous active-low reset
// e_id_i       in   NUM_EVENTS       event pulses, one bit per line, sampled every cycle
// e_info_i     in   2+ASID_WIDTH     {priv, asid}; priv 01=M, 10=S, 11=U, 00=invalid
// s_id_i       in   1                source id of this event beat
// cfg_req_i    in   1                register access strobe (one cycle per access)
// cfg_we_i     in   1                1 = write, 0 = read
// cfg_addr_i   in   6                word address
// cfg_wdata_i  in   32               write data
// cfg_rvalid_o out  1                read data valid, exactly 1 cycle after a read req
// cfg_rdata_o  out  32               read data; 0 when cfg_rvalid_o=0
// irq_o        out  1                |(hit_sticky & irq_en), registered
// BEHAVIOUR
// - Reset: all counters, thresholds, sticky flags, CTRL and ASID_MATCH = 0; outputs = 0.
// - Register map (word address). Unmapped reads return 0; unmapped writes are ignored.
//   0x00 CTRL: [0] en, [1] asid_flt_en, [2] M_en, [3] S_en, [4] U_en,
//        [5] clr_all (write-only, self-clearing), [31:16] irq_en[NUM_EVENTS-1:0].
//   0x01 ASID_MATCH [ASID_WIDTH-1:0].
//   0x02 STATUS: [15:0] hit_sticky, [31:16] ovf_sticky. Write 1 to clear.
//   0x10+i COUNT_i (R/W).  0x20+i THRESH_i (R/W); THRESH = 0 disables the hit flag.
// - Pipeline stage 1: e_id, e_info and s_id are registered unconditionally.
// - Stage 2 accept = en & (s_id==SRC_ID) & priv_ok & (~asid_flt_en | asid==ASID_MATCH).
//   priv_ok requires the matching M_en/S_en/U_en bit; priv 00 is never accepted.
// - If accept & e_id[i], COUNT_i increments by 1. The new value is readable 2 cycles after
//   the event is presented on the inputs (event at cycle N, read req at N+2 sees it).
// - Wrap: an increment from all-ones wraps to 0 and sets ovf_sticky[i] in the same cycle.
// - Hit: if THRESH_i != 0 and the incremented value == THRESH_i, set hit_sticky[i].
//   Writes to COUNT_i or THRESH_i never set hit_sticky.
// - irq_o is registered and follows hit_sticky & irq_en with 1-cycle latency.
// - Simultaneous events in the same cycle:
//   * Register write to COUNT_i and increment of line i: the write wins and the
//     increment is lost.
//   * clr_all and increment: counters end at 0 and all sticky flags are cleared.
//     THRESH and CTRL are kept.
//   * W1C on STATUS and set of the same flag: the set wins and the flag stays 1.
// - Read data is captured at req time and reflects the pre-write state. It does not
//   include an increment occurring in that same cycle.
// - A read and a write cannot occur together (single strobe). A req in consecutive cycles
//   is allowed; each read has its own rvalid pulse.
// - Reset asserted mid-operation clears the pipeline immediately; in-flight events are
//   dropped.
// - Widths: CNT_WIDTH < 32 zero-extends on read and truncates on write.
// TESTING
// 1. Reset, then read all registers -> all 0; irq_o=0, cfg_rvalid_o=0.
// 2. CTRL=0x1D (en, M/S/U), pulse e_id=4'b0101 for 3 cycles, priv=01
//    -> COUNT_0=3, COUNT_2=3, COUNT_1=COUNT_3=0.
// 3. CTRL=0x07 (en, asid_flt, M only), ASID_MATCH=5. Send events with asid=5/priv=S,
//    asid=6/priv=M and asid=5/priv=M, all on line 1 -> COUNT_1=1.
//    Also send s_id=1 -> dropped.
// 4. THRESH_0=2, irq_en[0]=1, two line-0 events -> hit_sticky[0]=1 and irq_o=1
//    one cycle later. W1C STATUS=0x1 -> irq_o=0.
// 5. COUNT_3=0xFFFFFFFF, one line-3 event -> COUNT_3=0, ovf_sticky[3]=1 (STATUS=0x0008_0000).
// 6. Write COUNT_2=7 in the same cycle as a line-2 increment -> COUNT_2=7. clr_all together
//    with an event -> all counters 0. Assert rst_ni mid-burst -> all registers 0.

Source files
------------

// File: rtl/spu_event_counter_if.sv
// SPU event/configuration bus between the event unit / SPU core (master) and
// the event counter (slave).
//   e_id      : per-line event pulses
//   e_info    : {priv[1:0], asid}
//   s_id      : source id of the event beat
//   cfg_req   : register access strobe, cfg_we selects write/read
//   cfg_addr  : word address, cfg_wdata: write data
//   cfg_rvalid: read data valid (1 cycle after a read req), cfg_rdata: read data
interface spu_event_counter_if #(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned ASID_WIDTH = 16
);
  logic [NUM_EVENTS-1:0]   e_id;
  logic [ASID_WIDTH+1:0]   e_info;
  logic                    s_id;
  logic                    cfg_req;
  logic                    cfg_we;
  logic [5:0]              cfg_addr;
  logic [31:0]             cfg_wdata;
  logic                    cfg_rvalid;
  logic [31:0]             cfg_rdata;

  modport master (
    output e_id, e_info, s_id, cfg_req, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rvalid, cfg_rdata
  );

  modport slave (
    input  e_id, e_info, s_id, cfg_req, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rvalid, cfg_rdata
  );
endinterface

// File: rtl/spu_event_counter.sv
// SPU event counter: receive end of the EVU event interface. One counter per
// event line, gated by enable/privilege/ASID/source filters, with per-line
// thresholds, sticky hit/overflow flags and a level interrupt.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : event inputs and single-cycle register port (slave modport)
//   irq_o  : |(hit_sticky & irq_en), registered
// Register map (word address): 0x00 CTRL, 0x01 ASID_MATCH, 0x02 STATUS (W1C),
// 0x10+i COUNT_i, 0x20+i THRESH_i.
module spu_event_counter #(
  parameter int unsigned NUM_EVENTS = 4,
  parameter int unsigned ASID_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic        SRC_ID     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spu_event_counter_if.slave   bus,
  output logic                 irq_o
);

  localparam int unsigned INFO_W = ASID_WIDTH + 2;

  // Stage 1 event capture
  logic [NUM_EVENTS-1:0] e_id_q;
  logic [INFO_W-1:0]     e_info_q;
  logic                  s_id_q;

  // Configuration and state
  logic                  en_q, asid_flt_q, m_en_q, s_en_q, u_en_q;
  logic [NUM_EVENTS-1:0] irq_en_q;
  logic [ASID_WIDTH-1:0] asid_match_q;
  logic [NUM_EVENTS-1:0] hit_q, ovf_q;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  thr_q [NUM_EVENTS];
  logic                  rvalid_q;
  logic [31:0]           rdata_q;
  logic                  irq_q;

  // Combinational decode
  logic                  wr, rd, clr_all, accept, priv_ok;
  logic [1:0]            priv;
  logic [ASID_WIDTH-1:0] asid;
  logic [NUM_EVENTS-1:0] inc, hit_set, ovf_set, cnt_wr, thr_wr;
  logic [NUM_EVENTS-1:0] hit_w1c, ovf_w1c;
  logic [CNT_WIDTH-1:0]  cnt_inc [NUM_EVENTS];
  logic [31:0]           rd_data;
  logic                  unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  always_comb begin
    wr      = bus.cfg_req & bus.cfg_we;
    rd      = bus.cfg_req & ~bus.cfg_we;
    clr_all = wr & (bus.cfg_addr == 6'h00) & bus.cfg_wdata[5];
    priv    = e_info_q[INFO_W-1 -: 2];
    asid    = e_info_q[ASID_WIDTH-1:0];
    priv_ok = ((priv == 2'b01) & m_en_q) |
              ((priv == 2'b10) & s_en_q) |
              ((priv == 2'b11) & u_en_q);
    accept  = en_q & (s_id_q == SRC_ID) & priv_ok &
              (~asid_flt_q | (asid == asid_match_q));

    hit_w1c = '0;
    ovf_w1c = '0;
    if (wr && bus.cfg_addr == 6'h02) begin
      hit_w1c = bus.cfg_wdata[NUM_EVENTS-1:0];
      ovf_w1c = bus.cfg_wdata[16 +: NUM_EVENTS];
    end

    inc     = '0;
    hit_set = '0;
    ovf_set = '0;
    cnt_wr  = '0;
    thr_wr  = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      cnt_inc[i] = cnt_q[i] + CNT_WIDTH'(1);
      inc[i]     = accept & e_id_q[i];
      hit_set[i] = inc[i] & (thr_q[i] != '0) & (cnt_inc[i] == thr_q[i]);
      ovf_set[i] = inc[i] & (cnt_q[i] == '1);
      cnt_wr[i]  = wr & (bus.cfg_addr[5:4] == 2'b01) & (bus.cfg_addr[3:0] == 4'(i));
      thr_wr[i]  = wr & (bus.cfg_addr[5:4] == 2'b10) & (bus.cfg_addr[3:0] == 4'(i));
    end

    // Read mux sees only registered state, so a same-cycle increment or
    // write is not reflected.
    rd_data = '0;
    case (bus.cfg_addr)
      6'h00: begin
        rd_data[0] = en_q;
        rd_data[1] = asid_flt_q;
        rd_data[2] = m_en_q;
        rd_data[3] = s_en_q;
        rd_data[4] = u_en_q;
        rd_data[16 +: NUM_EVENTS] = irq_en_q;
      end
      6'h01: rd_data[ASID_WIDTH-1:0] = asid_match_q;
      6'h02: begin
        rd_data[NUM_EVENTS-1:0]   = hit_q;
        rd_data[16 +: NUM_EVENTS] = ovf_q;
      end
      default: begin
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
          if (bus.cfg_addr == {2'b01, 4'(i)}) rd_data[CNT_WIDTH-1:0] = cnt_q[i];
          if (bus.cfg_addr == {2'b10, 4'(i)}) rd_data[CNT_WIDTH-1:0] = thr_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      e_id_q       <= '0;
      e_info_q     <= '0;
      s_id_q       <= 1'b0;
      en_q         <= 1'b0;
      asid_flt_q   <= 1'b0;
      m_en_q       <= 1'b0;
      s_en_q       <= 1'b0;
      u_en_q       <= 1'b0;
      irq_en_q     <= '0;
      asid_match_q <= '0;
      hit_q        <= '0;
      ovf_q        <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        cnt_q[i] <= '0;
        thr_q[i] <= '0;
      end
    end else begin
      e_id_q   <= bus.e_id;
      e_info_q <= bus.e_info;
      s_id_q   <= bus.s_id;

      if (wr && bus.cfg_addr == 6'h00) begin
        en_q       <= bus.cfg_wdata[0];
        asid_flt_q <= bus.cfg_wdata[1];
        m_en_q     <= bus.cfg_wdata[2];
        s_en_q     <= bus.cfg_wdata[3];
        u_en_q     <= bus.cfg_wdata[4];
        irq_en_q   <= bus.cfg_wdata[16 +: NUM_EVENTS];
      end
      if (wr && bus.cfg_addr == 6'h01) asid_match_q <= bus.cfg_wdata[ASID_WIDTH-1:0];

      // clr_all beats everything; otherwise a flag set beats its W1C.
      if (clr_all) begin
        hit_q <= '0;
        ovf_q <= '0;
      end else begin
        hit_q <= (hit_q & ~hit_w1c) | hit_set;
        ovf_q <= (ovf_q & ~ovf_w1c) | ovf_set;
      end

      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (clr_all)        cnt_q[i] <= '0;
        else if (cnt_wr[i]) cnt_q[i] <= bus.cfg_wdata[CNT_WIDTH-1:0];
        else if (inc[i])    cnt_q[i] <= cnt_inc[i];
        if (thr_wr[i])      thr_q[i] <= bus.cfg_wdata[CNT_WIDTH-1:0];
      end

      rvalid_q <= rd;
      rdata_q  <= rd ? rd_data : '0;
      irq_q    <= |(hit_q & irq_en_q);
    end
  end

  assign bus.cfg_rvalid = rvalid_q;
  assign bus.cfg_rdata  = rdata_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_spu_event_counter.sv
module tb_spu_event_counter;

  localparam int OP_W = 0, OP_R = 1, OP_EV = 2, OP_IRQ = 3, OP_IDLE = 4;

  typedef struct {
    int          op;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic [3:0]  eid;
    logic [1:0]  priv;
    logic [15:0] asid;
    logic        sid;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  logic [31:0] rdv;

  always #5 clk = ~clk;

  spu_event_counter_if #(.NUM_EVENTS(4), .ASID_WIDTH(16)) bus ();

  spu_event_counter #(
    .NUM_EVENTS(4),
    .ASID_WIDTH(16),
    .CNT_WIDTH (32),
    .SRC_ID    (1'b0)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus.slave),
    .irq_o (irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void add(input int op, input logic [5:0] a, input logic [31:0] d,
                              input logic [31:0] e, input logic [3:0] eid = 4'h0,
                              input logic [1:0] pr = 2'b01, input logic [15:0] as = 16'h0,
                              input logic sid = 1'b0);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e;
    v.eid = eid; v.priv = pr; v.asid = as; v.sid = sid;
    vecs.push_back(v);
  endfunction

  task automatic ev_set(input logic [3:0] eid, input logic [1:0] pr,
                        input logic [15:0] as, input logic sid);
    bus.e_id   = eid;
    bus.e_info = {pr, as};
    bus.s_id   = sid;
  endtask

  task automatic cfg_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
    @(negedge clk);
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string nm, input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = a;
    @(negedge clk);
    bus.cfg_req = 1'b0;
    check({nm, "_rvalid"}, {31'b0, bus.cfg_rvalid}, 32'h1);
    d = bus.cfg_rdata;
  endtask

  task automatic apply(input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      string nm;
      nm = $sformatf("vec%0d_a%02h", k, vecs[k].addr);
      case (vecs[k].op)
        OP_W: cfg_write(vecs[k].addr, vecs[k].data);
        OP_R: begin
          cfg_read(nm, vecs[k].addr, rdv);
          check(nm, rdv, vecs[k].exp);
        end
        OP_EV: begin
          @(negedge clk);
          ev_set(vecs[k].eid, vecs[k].priv, vecs[k].asid, vecs[k].sid);
          @(negedge clk);
          ev_set(4'h0, 2'b00, 16'h0, 1'b0);
        end
        OP_IRQ: begin
          @(negedge clk);
          check({nm, "_irq"}, {31'b0, irq}, vecs[k].exp);
        end
        default: begin
          @(negedge clk);
          check({nm, "_idle_rvalid"}, {31'b0, bus.cfg_rvalid}, 32'h0);
          check({nm, "_idle_rdata"}, bus.cfg_rdata, 32'h0);
        end
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p0, p1, p2, p3, p4, p5, p6, p7;
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);

    // Reset state: every mapped register plus one unmapped address
    p0 = vecs.size();
    add(OP_IDLE, 6'h00, 0, 0);
    add(OP_IRQ, 6'h00, 0, 0);
    for (int i = 0; i < 3; i++) add(OP_R, 6'(i), 0, 0);
    for (int i = 0; i < 4; i++) add(OP_R, 6'(16 + i), 0, 0);
    for (int i = 0; i < 4; i++) add(OP_R, 6'(32 + i), 0, 0);
    add(OP_R, 6'h3F, 0, 0);
    // Basic counting on lines 0 and 2
    p1 = vecs.size();
    add(OP_W, 6'h00, 32'h1D, 0);
    for (int i = 0; i < 3; i++) add(OP_EV, 0, 0, 0, 4'b0101, 2'b01);
    add(OP_R, 6'h10, 0, 3); add(OP_R, 6'h11, 0, 0);
    add(OP_R, 6'h12, 0, 3); add(OP_R, 6'h13, 0, 0);
    // Privilege / ASID / source filtering on line 1
    p2 = vecs.size();
    add(OP_W, 6'h11, 0, 0);
    add(OP_W, 6'h00, 32'h07, 0);
    add(OP_W, 6'h01, 32'h5, 0);
    add(OP_R, 6'h00, 0, 32'h07);
    add(OP_R, 6'h01, 0, 32'h5);
    add(OP_EV, 0, 0, 0, 4'b0010, 2'b10, 16'd5);
    add(OP_EV, 0, 0, 0, 4'b0010, 2'b01, 16'd6);
    add(OP_EV, 0, 0, 0, 4'b0010, 2'b01, 16'd5);
    add(OP_EV, 0, 0, 0, 4'b0010, 2'b01, 16'd5, 1'b1);
    add(OP_EV, 0, 0, 0, 4'b0010, 2'b00, 16'd5);
    add(OP_R, 6'h11, 0, 1);
    // Threshold setup and first line-0 event
    p3 = vecs.size();
    add(OP_W, 6'h10, 0, 0);
    add(OP_W, 6'h20, 32'h2, 0);
    add(OP_W, 6'h00, 32'h0001_001D, 0);
    add(OP_R, 6'h20, 0, 2);
    add(OP_R, 6'h00, 0, 32'h0001_001D);
    add(OP_EV, 0, 0, 0, 4'b0001, 2'b01);
    add(OP_R, 6'h02, 0, 0);
    p4 = vecs.size();
    // Hit flag, W1C, irq release
    add(OP_IRQ, 0, 0, 1);
    add(OP_R, 6'h02, 0, 32'h1);
    add(OP_W, 6'h02, 32'h1, 0);
    add(OP_IRQ, 0, 0, 0);
    add(OP_R, 6'h02, 0, 0);
    // Wrap on line 3
    p5 = vecs.size();
    add(OP_W, 6'h13, 32'hFFFF_FFFF, 0);
    add(OP_R, 6'h13, 0, 32'hFFFF_FFFF);
    add(OP_EV, 0, 0, 0, 4'b1000, 2'b01);
    add(OP_R, 6'h13, 0, 0);
    add(OP_R, 6'h02, 0, 32'h0008_0000);
    add(OP_IRQ, 0, 0, 0);
    add(OP_W, 6'h02, 32'h0008_0000, 0);
    add(OP_R, 6'h02, 0, 0);
    // State after clr_all with a concurrent event
    p6 = vecs.size();
    for (int i = 0; i < 4; i++) add(OP_R, 6'(16 + i), 0, 0);
    add(OP_R, 6'h02, 0, 0);
    add(OP_R, 6'h00, 0, 32'h0001_001D);
    add(OP_R, 6'h20, 0, 2);
    add(OP_IRQ, 0, 0, 0);
    p7 = vecs.size();

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    apply(p0, p1);
    apply(p1, p2);

    // Latency: event at N, back-to-back reads at N+1 (old) and N+2 (new)
    @(negedge clk);
    ev_set(4'b0010, 2'b01, 16'h0, 1'b0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 6'h11;
    @(negedge clk);
    check("lat_n1_rvalid", {31'b0, bus.cfg_rvalid}, 32'h1);
    check("lat_n1_rdata", bus.cfg_rdata, 32'h0);
    @(negedge clk);
    bus.cfg_req = 1'b0;
    check("lat_n2_rvalid", {31'b0, bus.cfg_rvalid}, 32'h1);
    check("lat_n2_rdata", bus.cfg_rdata, 32'h1);

    apply(p2, p3);
    apply(p3, p4);

    // Second line-0 event reaches THRESH_0; irq follows the flag one cycle later
    @(negedge clk);
    ev_set(4'b0001, 2'b01, 16'h0, 1'b0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    @(negedge clk);
    check("irq_same_cycle_as_hit", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_one_cycle_after_hit", {31'b0, irq}, 32'h1);

    apply(p4, p5);
    apply(p5, p6);

    // W1C of hit_sticky[0] in the same cycle the flag is set: set wins
    cfg_write(6'h10, 32'h1);
    @(negedge clk);
    ev_set(4'b0001, 2'b01, 16'h0, 1'b0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 6'h02; bus.cfg_wdata = 32'h1;
    @(negedge clk);
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0;
    cfg_read("w1c_vs_set", 6'h02, rdv);
    check("w1c_vs_set", rdv, 32'h1);
    cfg_write(6'h02, 32'h1);

    // COUNT_2 write coincident with a line-2 increment: write wins
    @(negedge clk);
    ev_set(4'b0100, 2'b01, 16'h0, 1'b0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 6'h12; bus.cfg_wdata = 32'h7;
    @(negedge clk);
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0;
    cfg_read("cnt_wr_vs_inc", 6'h12, rdv);
    check("cnt_wr_vs_inc", rdv, 32'h7);

    // clr_all coincident with events on all lines (line 0 would hit THRESH_0)
    cfg_write(6'h10, 32'h1);
    @(negedge clk);
    ev_set(4'b1111, 2'b01, 16'h0, 1'b0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b1; bus.cfg_addr = 6'h00; bus.cfg_wdata = 32'h0001_003D;
    @(negedge clk);
    bus.cfg_req = 1'b0; bus.cfg_we = 1'b0;
    apply(p6, p7);

    // Reset in the middle of a continuous burst
    @(negedge clk);
    ev_set(4'b1111, 2'b01, 16'h0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check("irq_before_reset", {31'b0, irq}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    @(negedge clk);
    ev_set(4'h0, 2'b00, 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(p0, p1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
